ysyx_22040750_lsu: RTL and testbench

// - Load/store unit in the MEM stage, directly upstream of the dcache controller (cpu-side port).
// - Accepts one load/store per transaction, aligns store data and byte mask into a 64-bit doubleword, issues a one-cycle rd/wr request.
// - Extracts and sign/zero-extends load data from the returned doubleword and signals completion to writeback.
// - Single outstanding access; stalls the pipeline via O_ready while busy.

---
 rtl/ysyx_22040750_lsu_pkg.sv | 53 +++++
 rtl/ysyx_22040750_lsu_align.sv | 51 +++++
 rtl/ysyx_22040750_lsu.sv | 134 +++++++++++++
 tb/tb_ysyx_22040750_lsu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040750_lsu_pkg.sv
// Shared LSU definitions: funct3 encodings, one-hot LSU state encoding,
// access-size masks and size/alignment helpers.
package ysyx_22040750_defs;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0f;
  localparam logic [7:0] MASK_D = 8'hff;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_REQ    = 5'b00010,
    ST_WAIT_R = 5'b00100,
    ST_WAIT_B = 5'b01000,
    ST_DONE   = 5'b10000
  } lsu_state_e;

  // Log2 of access size; store 1xx and load 111 fall back to doubleword.
  function automatic logic [1:0] eff_size(input logic is_store, input logic [2:0] f3);
    eff_size = (is_store && f3[2]) ? 2'b11 : f3[1:0];
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = MASK_B;
      2'b01:   size_mask = MASK_H;
      2'b10:   size_mask = MASK_W;
      default: size_mask = MASK_D;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040750_lsu_align.sv
// Combinational store data/byte-mask alignment and load extract/extend
// within a 64-bit doubleword.
module ysyx_22040750_lsu_align
  import ysyx_22040750_defs::*;
(
  input  logic        st_is_store,
  input  logic [2:0]  st_funct3,
  input  logic [2:0]  st_off,
  input  logic [63:0] st_wdata,
  output logic [63:0] st_data,
  output logic [7:0]  st_mask,
  input  logic [2:0]  ld_funct3,
  input  logic [2:0]  ld_off,
  input  logic [63:0] ld_raw,
  output logic [63:0] ld_data
);

  function automatic logic signed [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                                input logic is_unsigned);
    logic signed [63:0] r;
    case (sz)
      2'b00:   r = is_unsigned ? {56'd0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
      2'b01:   r = is_unsigned ? {48'd0, v[15:0]} : {{48{v[15]}}, v[15:0]};
      2'b10:   r = is_unsigned ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
      default: r = v;
    endcase
    extend = r;
  endfunction

  logic [1:0]  st_sz;
  logic [14:0] mask_wide;
  logic [63:0] ld_shifted;
  logic [1:0]  ld_sz;
  logic        ld_unsigned;

  always_comb begin
    st_sz     = eff_size(1'b1, st_funct3);
    // Bytes shifted past the doubleword boundary are dropped here.
    mask_wide = {7'd0, size_mask(st_sz)} << st_off;
    st_data   = st_is_store ? (st_wdata << {st_off, 3'b000}) : 64'd0;
    st_mask   = st_is_store ? mask_wide[7:0] : 8'd0;
  end

  always_comb begin
    ld_sz       = eff_size(1'b0, ld_funct3);
    ld_unsigned = ld_funct3[2] && (ld_funct3[1:0] != 2'b11);
    ld_shifted  = ld_raw >> {ld_off, 3'b000};
    ld_data     = extend(ld_shifted, ld_sz, ld_unsigned);
  end

endmodule

// File: rtl/ysyx_22040750_lsu.sv
// MEM-stage load/store unit in front of the dcache cpu port; single outstanding access.
// Optional misaligned-access trap: define YSYX_22040750_LSU_MISALIGN_TRAP_EN.
module ysyx_22040750_lsu
  import ysyx_22040750_defs::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_valid,
  input  logic              I_is_load,
  input  logic              I_is_store,
  input  logic [2:0]        I_funct3,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [XLEN-1:0]   I_wdata,
  input  logic [4:0]        I_rd_idx,
  output logic              O_ready,
  output logic              O_valid,
  output logic [XLEN-1:0]   O_rdata,
  output logic [4:0]        O_rd_idx,
  output logic              O_misalign,
  output logic [ADDR_W-1:0] O_cpu_addr,
  output logic [XLEN-1:0]   O_cpu_data,
  output logic [7:0]        O_cpu_wmask,
  output logic              O_cpu_rd_req,
  output logic              O_cpu_wr_req,
  input  logic              I_cpu_mem_ready,
  input  logic [XLEN-1:0]   I_cpu_data,
  input  logic              I_cpu_rvalid,
  input  logic              I_cpu_bvalid
);

  lsu_state_e state, state_nxt;

  logic [ADDR_W-1:0] addr_p0;
  logic [2:0]        funct3_p0;
  logic              is_store_p0;
  logic [XLEN-1:0]   data_p0;
  logic [7:0]        mask_p0;
  logic [4:0]        rd_idx_p0;
  logic [XLEN-1:0]   rdata_p1;

  logic              accept;
  logic              acc_mis;
  logic [XLEN-1:0]   st_data;
  logic [7:0]        st_mask;
  logic [XLEN-1:0]   ld_data;

  assign accept = I_valid && (state == ST_IDLE) && (I_is_load || I_is_store);

  ysyx_22040750_lsu_align u_align (
    .st_is_store (I_is_store),
    .st_funct3   (I_funct3),
    .st_off      (I_addr[2:0]),
    .st_wdata    (I_wdata),
    .st_data     (st_data),
    .st_mask     (st_mask),
    .ld_funct3   (funct3_p0),
    .ld_off      (addr_p0[2:0]),
    .ld_raw      (I_cpu_data),
    .ld_data     (ld_data)
  );

`ifdef YSYX_22040750_LSU_MISALIGN_TRAP_EN
  logic mis_p0;

  assign acc_mis = is_misaligned(eff_size(I_is_store, I_funct3), I_addr[2:0]);

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst)       mis_p0 <= 1'b0;
    else if (accept) mis_p0 <= acc_mis;
  end

  assign O_misalign = O_valid && mis_p0;
`else
  assign acc_mis    = 1'b0;
  assign O_misalign = 1'b0;
`endif

  // Stage p0: op capture on accept
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state       <= ST_IDLE;
      addr_p0     <= '0;
      funct3_p0   <= '0;
      is_store_p0 <= 1'b0;
      data_p0     <= '0;
      mask_p0     <= '0;
      rd_idx_p0   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_p0     <= I_addr;
        funct3_p0   <= I_funct3;
        is_store_p0 <= I_is_store;
        data_p0     <= st_data;
        mask_p0     <= st_mask;
        rd_idx_p0   <= I_rd_idx;
      end
    end
  end

  // Stage p1: load result capture
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst)                                     rdata_p1 <= '0;
    else if (accept)                               rdata_p1 <= '0;
    else if (state == ST_WAIT_R && I_cpu_rvalid)   rdata_p1 <= ld_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = acc_mis ? ST_DONE : ST_REQ;
      ST_REQ:    if (I_cpu_mem_ready) state_nxt = is_store_p0 ? ST_WAIT_B : ST_WAIT_R;
      ST_WAIT_R: if (I_cpu_rvalid) state_nxt = ST_DONE;
      ST_WAIT_B: if (I_cpu_bvalid) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Requests are combinational on state so an async reset drops them at once.
  assign O_cpu_rd_req = (state == ST_REQ) && I_cpu_mem_ready && !is_store_p0;
  assign O_cpu_wr_req = (state == ST_REQ) && I_cpu_mem_ready &&  is_store_p0;
  assign O_ready      = (state == ST_IDLE);
  assign O_valid      = (state == ST_DONE);
  assign O_rdata      = rdata_p1;
  assign O_rd_idx     = rd_idx_p0;
  assign O_cpu_addr   = addr_p0;
  assign O_cpu_data   = data_p0;
  assign O_cpu_wmask  = mask_p0;

endmodule

// File: tb/tb_ysyx_22040750_lsu.sv
// Directed self-checking bench for ysyx_22040750_lsu.
module tb_ysyx_22040750_lsu;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_valid, I_is_load, I_is_store;
  logic [2:0]  I_funct3;
  logic [31:0] I_addr;
  logic [63:0] I_wdata;
  logic [4:0]  I_rd_idx;
  logic        O_ready, O_valid, O_misalign, O_cpu_rd_req, O_cpu_wr_req;
  logic [63:0] O_rdata, O_cpu_data;
  logic [4:0]  O_rd_idx;
  logic [31:0] O_cpu_addr;
  logic [7:0]  O_cpu_wmask;
  logic        I_cpu_mem_ready, I_cpu_rvalid, I_cpu_bvalid;
  logic [63:0] I_cpu_data;

  int checks = 0;
  int errors = 0;

  ysyx_22040750_lsu dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_valid(I_valid), .I_is_load(I_is_load),
    .I_is_store(I_is_store), .I_funct3(I_funct3), .I_addr(I_addr), .I_wdata(I_wdata),
    .I_rd_idx(I_rd_idx), .O_ready(O_ready), .O_valid(O_valid), .O_rdata(O_rdata),
    .O_rd_idx(O_rd_idx), .O_misalign(O_misalign), .O_cpu_addr(O_cpu_addr),
    .O_cpu_data(O_cpu_data), .O_cpu_wmask(O_cpu_wmask), .O_cpu_rd_req(O_cpu_rd_req),
    .O_cpu_wr_req(O_cpu_wr_req), .I_cpu_mem_ready(I_cpu_mem_ready),
    .I_cpu_data(I_cpu_data), .I_cpu_rvalid(I_cpu_rvalid), .I_cpu_bvalid(I_cpu_bvalid)
  );

  always #5 I_clk = ~I_clk;

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept_op(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    I_valid = 1'b1; I_is_load = ld; I_is_store = st; I_funct3 = f3;
    I_addr = addr; I_wdata = wd; I_rd_idx = rd;
    tick();
    I_valid = 1'b0; I_is_load = 1'b0; I_is_store = 1'b0;
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [63:0] wd, input logic [63:0] exp_data,
                           input logic [7:0] exp_mask);
    accept_op(1'b0, 1'b1, f3, addr, wd, 5'd7);
    chk({tag, "_wr_req"}, 64'(O_cpu_wr_req), 64'd1);
    chk({tag, "_rd_req"}, 64'(O_cpu_rd_req), 64'd0);
    chk({tag, "_data"}, O_cpu_data, exp_data);
    chk({tag, "_mask"}, 64'(O_cpu_wmask), 64'(exp_mask));
    chk({tag, "_addr"}, 64'(O_cpu_addr), 64'(addr));
    chk({tag, "_ready_busy"}, 64'(O_ready), 64'd0);
    tick();
    chk({tag, "_wr_req_drop"}, 64'(O_cpu_wr_req), 64'd0);
    I_cpu_rvalid = 1'b1;
    tick();
    I_cpu_rvalid = 1'b0;
    chk({tag, "_rvalid_ignored"}, 64'(O_valid), 64'd0);
    I_cpu_bvalid = 1'b1;
    tick();
    I_cpu_bvalid = 1'b0;
    chk({tag, "_valid"}, 64'(O_valid), 64'd1);
    chk({tag, "_rdata0"}, O_rdata, 64'd0);
    chk({tag, "_rd_idx"}, 64'(O_rd_idx), 64'd7);
    tick();
    chk({tag, "_valid_pulse"}, 64'(O_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(O_ready), 64'd1);
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] raw, input logic [63:0] exp);
    accept_op(1'b1, 1'b0, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9);
    chk({tag, "_rd_req"}, 64'(O_cpu_rd_req), 64'd1);
    chk({tag, "_wr_req"}, 64'(O_cpu_wr_req), 64'd0);
    chk({tag, "_mask0"}, 64'(O_cpu_wmask), 64'd0);
    chk({tag, "_data0"}, O_cpu_data, 64'd0);
    tick();
    chk({tag, "_rd_req_drop"}, 64'(O_cpu_rd_req), 64'd0);
    I_cpu_bvalid = 1'b1;
    tick();
    I_cpu_bvalid = 1'b0;
    chk({tag, "_bvalid_ignored"}, 64'(O_valid), 64'd0);
    I_cpu_data = raw; I_cpu_rvalid = 1'b1;
    tick();
    I_cpu_rvalid = 1'b0; I_cpu_data = 64'd0;
    chk({tag, "_valid"}, 64'(O_valid), 64'd1);
    chk({tag, "_rdata"}, O_rdata, exp);
    chk({tag, "_misalign"}, 64'(O_misalign), 64'd0);
    chk({tag, "_rd_idx"}, 64'(O_rd_idx), 64'd9);
    tick();
    chk({tag, "_valid_pulse"}, 64'(O_valid), 64'd0);
  endtask

  initial begin
    I_rst = 1'b1; I_valid = 1'b0; I_is_load = 1'b0; I_is_store = 1'b0;
    I_funct3 = 3'd0; I_addr = 32'd0; I_wdata = 64'd0; I_rd_idx = 5'd0;
    I_cpu_mem_ready = 1'b1; I_cpu_rvalid = 1'b0; I_cpu_bvalid = 1'b0; I_cpu_data = 64'd0;
    repeat (3) tick();
    chk("rst_ready", 64'(O_ready), 64'd1);
    chk("rst_valid", 64'(O_valid), 64'd0);
    chk("rst_reqs", {62'd0, O_cpu_rd_req, O_cpu_wr_req}, 64'd0);
    chk("rst_misalign", 64'(O_misalign), 64'd0);
    chk("rst_addr", 64'(O_cpu_addr), 64'd0);
    chk("rst_data", O_cpu_data, 64'd0);
    chk("rst_mask", 64'(O_cpu_wmask), 64'd0);
    chk("rst_rdata", O_rdata, 64'd0);
    I_rst = 1'b0;
    tick();

    // Non-memory op is ignored
    I_valid = 1'b1;
    tick();
    I_valid = 1'b0;
    chk("nonmem_ready", 64'(O_ready), 64'd1);
    chk("nonmem_reqs", {62'd0, O_cpu_rd_req, O_cpu_wr_req}, 64'd0);
    tick();
    chk("nonmem_valid", 64'(O_valid), 64'd0);

    run_store("sd", 3'b011, 32'h8000_0010, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 8'hff);
    run_store("sb", 3'b000, 32'h8000_0013, 64'h0000_0000_0000_00AB, 64'h0000_0000_AB00_0000, 8'h08);
    run_store("sh", 3'b001, 32'h8000_0002, 64'h0000_0000_0000_CAFE, 64'h0000_0000_CAFE_0000, 8'h0c);
    run_store("sw", 3'b010, 32'h8000_0004, 64'h0000_0000_DEAD_BEEF, 64'hDEAD_BEEF_0000_0000, 8'hf0);

    run_load("lb",  3'b000, 32'h8000_0005, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    run_load("lbu", 3'b100, 32'h8000_0005, 64'h0000_8000_0000_0000, 64'h0000_0000_0000_0080);
    run_load("lh",  3'b001, 32'h8000_0006, 64'hBEEF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_BEEF);
    run_load("lhu", 3'b101, 32'h8000_0006, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF);
    run_load("lwu", 3'b110, 32'h8000_0004, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF);
    run_load("ld",  3'b011, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // LW with dcache not ready for three cycles
    I_cpu_mem_ready = 1'b0;
    accept_op(1'b1, 1'b0, 3'b010, 32'h8000_0004, 64'd0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      chk("lw_stall_no_req", 64'(O_cpu_rd_req), 64'd0);
      chk("lw_stall_ready", 64'(O_ready), 64'd0);
      tick();
    end
    I_cpu_mem_ready = 1'b1;
    #1;
    chk("lw_req_on_ready", 64'(O_cpu_rd_req), 64'd1);
    tick();
    chk("lw_req_single", 64'(O_cpu_rd_req), 64'd0);
    chk("lw_wait_ready", 64'(O_ready), 64'd0);
    I_cpu_data = 64'h89AB_CDEF_0000_0000; I_cpu_rvalid = 1'b1;
    tick();
    I_cpu_rvalid = 1'b0;
    chk("lw_valid", 64'(O_valid), 64'd1);
    chk("lw_rdata", O_rdata, 64'hFFFF_FFFF_89AB_CDEF);
    chk("lw_rd_idx", 64'(O_rd_idx), 64'd3);
    tick();

    // Asynchronous reset while waiting for read data
    accept_op(1'b1, 1'b0, 3'b011, 32'h8000_0020, 64'd0, 5'd4);
    tick();
    chk("rstmid_in_wait", 64'(O_ready), 64'd0);
    I_rst = 1'b1;
    #1;
    chk("rstmid_ready_async", 64'(O_ready), 64'd1);
    chk("rstmid_no_req", 64'(O_cpu_rd_req), 64'd0);
    tick();
    I_rst = 1'b0;
    I_cpu_data = 64'h5555_5555_5555_5555; I_cpu_rvalid = 1'b1;
    tick();
    I_cpu_rvalid = 1'b0;
    chk("rstmid_no_valid", 64'(O_valid), 64'd0);
    chk("rstmid_ready", 64'(O_ready), 64'd1);
    tick();
    chk("rstmid_no_valid2", 64'(O_valid), 64'd0);

`ifdef YSYX_22040750_LSU_MISALIGN_TRAP_EN
    accept_op(1'b1, 1'b0, 3'b010, 32'h8000_0002, 64'd0, 5'd6);
    chk("mis_no_req", 64'(O_cpu_rd_req), 64'd0);
    chk("mis_valid", 64'(O_valid), 64'd1);
    chk("mis_flag", 64'(O_misalign), 64'd1);
    chk("mis_rdata", O_rdata, 64'd0);
    tick();
    chk("mis_ready", 64'(O_ready), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
